multdiv_iter: RTL

MULTDIV_ITER -- requirements
Module: multdiv_iter

---
 rtl/multdiv_iter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multdiv_iter.sv
// Iterative 32-bit signed multiplier/divider: one shift-add or restoring-divide
// step per clock, 32 steps per operation, one-cycle completion strobe.
module multdiv_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] in_IR,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] out_IR
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_opa;
  logic [W-1:0]     r_opb;
  logic [W-1:0]     r_ir;
  logic [W-1:0]     r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_dmag;

  logic             w_can_start;
  logic             w_go_mul;
  logic             w_go_div;
  logic [W-1:0]     w_amag_in;
  logic [W-1:0]     w_bmag_in;
  logic             w_neg;
  logic             w_last;
  logic [2*W-1:0]   w_acc_next;
  logic [2*W-1:0]   w_prod;
  logic             w_mul_ovf;
  logic [W:0]       w_trial;
  logic             w_ge;
  logic [W-1:0]     w_sub;
  logic [W-1:0]     w_rem_next;
  logic [W-1:0]     w_quo_next;
  logic [W-1:0]     w_quo_signed;
  logic             w_div0;
  logic             w_div_ovf;

  // A start needs exactly one request line and a non-busy engine
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_go_mul    = w_can_start && ctrl_MULT && !ctrl_DIV;
  assign w_go_div    = w_can_start && ctrl_DIV && !ctrl_MULT;

  assign w_amag_in = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
  assign w_bmag_in = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;
  assign w_neg     = r_opa[W-1] ^ r_opb[W-1];
  assign w_last    = (r_cnt == CW'(W - 1));

  // Unsigned shift-add on magnitudes; sign applied to the full 64-bit product
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod     = w_neg ? (2*W)'(-w_acc_next) : w_acc_next;
  assign w_mul_ovf  = !((&w_prod[2*W-1:W-1]) || !(|w_prod[2*W-1:W-1]));

  // Restoring division: remainder stays below the divisor so 32 bits suffice
  assign w_trial      = {r_rem, r_quo[W-1]};
  assign w_ge         = (w_trial >= {1'b0, r_dmag});
  assign w_sub        = w_trial[W-1:0] - r_dmag;
  assign w_rem_next   = w_ge ? w_sub : w_trial[W-1:0];
  assign w_quo_next   = {r_quo[W-2:0], w_ge};
  assign w_quo_signed = w_neg ? W'(-w_quo_next) : w_quo_next;
  assign w_div0       = (r_opb == '0);
  assign w_div_ovf    = (r_opa == 32'h8000_0000) && (r_opb == 32'hFFFF_FFFF);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_ir     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dmag   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
          if (w_go_mul || w_go_div) begin
            r_state  <= w_go_mul ? S_MUL : S_DIV;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_opa    <= data_operandA;
            r_opb    <= data_operandB;
            r_ir     <= in_IR;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, w_amag_in};
            r_mplier <= w_bmag_in;
            r_rem    <= '0;
            r_quo    <= w_amag_in;
            r_dmag   <= w_bmag_in;
          end
        end
        S_MUL: begin
          r_cnt    <= r_cnt + CW'(1);
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[W-1:1]};
          if (w_last) begin
            r_result <= w_prod[W-1:0];
            r_exc    <= w_mul_ovf;
            r_state  <= S_DONE;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (w_last) begin
            r_result <= w_div0 ? '0 : (w_div_ovf ? 32'h8000_0000 : w_quo_signed);
            r_exc    <= w_div0 || w_div_ovf;
            r_state  <= S_DONE;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
  assign out_IR         = r_ir;

endmodule
